// File: rtl/nmea_frame_ctrl.sv
// nmea_frame_ctrl: framing controller for NMEA-0183 sentences received one byte
// at a time. It checks the "$<HDR>" header, reports each payload character with
// its field/char position, and verifies the trailing "*HH" XOR checksum.
// All outputs are registered and respond one cycle after the po_flag strobe.
// Optional feature: define NMEA_TIMEOUT_EN to abort a frame after TO_CYC idle
// cycles (err_code 3).
module nmea_frame_ctrl #(
    parameter logic [39:0] HDR     = "GNRMC",
    parameter logic [7:0]  MAX_LEN = 8'd82,
    parameter logic [23:0] TO_CYC  = 24'd500000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] po_data,
    input  logic       po_flag,
    output logic       frame_start,
    output logic       char_strobe,
    output logic [7:0] char_data,
    output logic [4:0] field_idx,
    output logic [3:0] char_idx,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BODY  = 3'd2,
        S_CK_HI = 3'd3,
        S_CK_LO = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  acc_r, acc_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        hdr_bad_r, hdr_bad_s;
    logic [3:0]  ck_hi_r, ck_hi_s;
    logic [3:0]  char_cnt_r, char_cnt_s;
    logic [4:0]  field_idx_r, field_idx_s;
    logic [3:0]  char_idx_r, char_idx_s;
    logic [7:0]  char_data_r, char_data_s;
    logic [1:0]  err_code_r, err_code_s;
    logic        frame_start_r, frame_start_s;
    logic        char_strobe_r, char_strobe_s;
    logic        frame_ok_r, frame_ok_s;
    logic        frame_err_r, frame_err_s;
    logic        busy_r, busy_s;
    logic        over_s;
    logic [4:0]  hex_s;

    // Header byte expected at byte position pos (1..5; '$' is position 0).
    function automatic logic [7:0] hdr_byte(input logic [7:0] pos);
        logic [7:0] b;
        case (pos)
            8'd1:    b = HDR[39:32];
            8'd2:    b = HDR[31:24];
            8'd3:    b = HDR[23:16];
            8'd4:    b = HDR[15:8];
            8'd5:    b = HDR[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Decode an uppercase hex digit: {valid, nibble}.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

`ifdef NMEA_TIMEOUT_EN
    logic [23:0] to_cnt_r;

    // Idle-cycle counter: cleared by every byte, runs only while a frame is open.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt_r <= 24'd0;
        end else if (po_flag || (state_r == S_IDLE)) begin
            to_cnt_r <= 24'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 24'd1;
        end
    end
`endif

    // Next-state and next-output decode for one received byte (or idle cycle).
    always_comb begin
        state_s       = state_r;
        acc_s         = acc_r;
        cnt_s         = cnt_r;
        hdr_bad_s     = hdr_bad_r;
        ck_hi_s       = ck_hi_r;
        char_cnt_s    = char_cnt_r;
        field_idx_s   = field_idx_r;
        char_idx_s    = char_idx_r;
        char_data_s   = char_data_r;
        err_code_s    = err_code_r;
        frame_start_s = 1'b0;
        char_strobe_s = 1'b0;
        frame_ok_s    = 1'b0;
        frame_err_s   = 1'b0;
        over_s        = ((cnt_r + 8'd1) >= MAX_LEN);
        hex_s         = hex_decode(po_data);
        if (po_flag) begin
            if (po_data == CH_DOLLAR) begin
                state_s   = S_HDR;
                acc_s     = 8'd0;
                cnt_s     = 8'd1;
                hdr_bad_s = 1'b0;
            end else begin
                cnt_s = cnt_r + 8'd1;
                case (state_r)
                    S_IDLE: begin
                        cnt_s = cnt_r;
                    end
                    S_HDR: begin
                        acc_s     = acc_r ^ po_data;
                        hdr_bad_s = hdr_bad_r | (po_data != hdr_byte(cnt_r));
                        if (over_s) begin
                            frame_err_s = 1'b1;
                            err_code_s  = 2'd2;
                            state_s     = S_IDLE;
                        end else if (cnt_r == 8'd5) begin
                            if (hdr_bad_s) begin
                                state_s = S_IDLE;
                            end else begin
                                state_s       = S_BODY;
                                frame_start_s = 1'b1;
                                field_idx_s   = 5'd0;
                                char_idx_s    = 4'd0;
                                char_cnt_s    = 4'd0;
                            end
                        end else begin
                            state_s = S_HDR;
                        end
                    end
                    S_BODY: begin
                        if (over_s) begin
                            frame_err_s = 1'b1;
                            err_code_s  = 2'd2;
                            state_s     = S_IDLE;
                        end else if (po_data == CH_COMMA) begin
                            acc_s       = acc_r ^ po_data;
                            field_idx_s = (field_idx_r == 5'd31) ? 5'd31 : field_idx_r + 5'd1;
                            char_idx_s  = 4'd0;
                            char_cnt_s  = 4'd0;
                        end else if (po_data == CH_STAR) begin
                            state_s = S_CK_HI;
                        end else begin
                            acc_s         = acc_r ^ po_data;
                            char_strobe_s = 1'b1;
                            char_data_s   = po_data;
                            char_idx_s    = char_cnt_r;
                            char_cnt_s    = (char_cnt_r == 4'd15) ? 4'd15 : char_cnt_r + 4'd1;
                        end
                    end
                    S_CK_HI: begin
                        if (over_s) begin
                            frame_err_s = 1'b1;
                            err_code_s  = 2'd2;
                            state_s     = S_IDLE;
                        end else if (!hex_s[4]) begin
                            frame_err_s = 1'b1;
                            err_code_s  = 2'd1;
                            state_s     = S_IDLE;
                        end else begin
                            ck_hi_s = hex_s[3:0];
                            state_s = S_CK_LO;
                        end
                    end
                    S_CK_LO: begin
                        state_s = S_IDLE;
                        if (!hex_s[4]) begin
                            frame_err_s = 1'b1;
                            err_code_s  = 2'd1;
                        end else if ({ck_hi_r, hex_s[3:0]} == acc_r) begin
                            frame_ok_s = 1'b1;
                        end else begin
                            frame_err_s = 1'b1;
                            err_code_s  = 2'd0;
                        end
                    end
                    default: begin
                        state_s = S_IDLE;
                    end
                endcase
            end
        end
`ifdef NMEA_TIMEOUT_EN
        else if ((state_r != S_IDLE) && (to_cnt_r == (TO_CYC - 24'd1))) begin
            frame_err_s = 1'b1;
            err_code_s  = 2'd3;
            state_s     = S_IDLE;
        end
`endif
        else begin
            state_s = state_r;
        end
        busy_s = (state_s != S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_r         <= 8'd0;
            cnt_r         <= 8'd0;
            hdr_bad_r     <= 1'b0;
            ck_hi_r       <= 4'd0;
            char_cnt_r    <= 4'd0;
            field_idx_r   <= 5'd0;
            char_idx_r    <= 4'd0;
            char_data_r   <= 8'd0;
            err_code_r    <= 2'd0;
            frame_start_r <= 1'b0;
            char_strobe_r <= 1'b0;
            frame_ok_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            acc_r         <= acc_s;
            cnt_r         <= cnt_s;
            hdr_bad_r     <= hdr_bad_s;
            ck_hi_r       <= ck_hi_s;
            char_cnt_r    <= char_cnt_s;
            field_idx_r   <= field_idx_s;
            char_idx_r    <= char_idx_s;
            char_data_r   <= char_data_s;
            err_code_r    <= err_code_s;
            frame_start_r <= frame_start_s;
            char_strobe_r <= char_strobe_s;
            frame_ok_r    <= frame_ok_s;
            frame_err_r   <= frame_err_s;
            busy_r        <= busy_s;
        end
    end

    assign frame_start = frame_start_r;
    assign char_strobe = char_strobe_r;
    assign char_data   = char_data_r;
    assign field_idx   = field_idx_r;
    assign char_idx    = char_idx_r;
    assign frame_ok    = frame_ok_r;
    assign frame_err   = frame_err_r;
    assign err_code    = err_code_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_nmea_frame_ctrl.sv
// Testbench for nmea_frame_ctrl. A frame-buffer reference model keeps the bytes
// of the open sentence and derives header match, field/char position and the
// checksum from that buffer. Every output is snapshotted one cycle after each
// byte and each idle cycle and compared with the model.
module tb_nmea_frame_ctrl;

    localparam int MAX_LEN = 82;
    localparam int TO      = 100;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] po_data = 8'd0;
    logic       po_flag = 1'b0;
    logic       frame_start, char_strobe, frame_ok, frame_err, busy;
    logic [7:0] char_data;
    logic [4:0] field_idx;
    logic [3:0] char_idx;
    logic [1:0] err_code;

    nmea_frame_ctrl #(
        .HDR     ("GNRMC"),
        .MAX_LEN (8'd82),
        .TO_CYC  (24'd100)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .po_data     (po_data),
        .po_flag     (po_flag),
        .frame_start (frame_start),
        .char_strobe (char_strobe),
        .char_data   (char_data),
        .field_idx   (field_idx),
        .char_idx    (char_idx),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // snapshot word: [23] busy [22] start [21] strobe [20] ok [19] err
    //                [18:17] code [16:12] field [11:8] char [7:0] data
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    logic [7:0]  stim[$];

    // reference model state
    logic [7:0]  fb[$];
    logic [4:0]  m_field;
    logic [3:0]  m_char;
    logic [7:0]  m_data;
    logic [1:0]  m_code;
    int          m_idle;
    string       hdr_str = "GNRMC";
    string       fchars  = "0123456789.,ANEW";

    function automatic logic [23:0] snap();
        return {busy, frame_start, char_strobe, frame_ok, frame_err, err_code,
                field_idx, char_idx, char_data};
    endfunction

    function automatic bit is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [7:0] v;
        if (c <= 8'h39) v = c - 8'h30;
        else            v = c - 8'h41 + 8'd10;
        return v[3:0];
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'd0, n};
        else           return 8'h41 + {4'd0, n} - 8'd10;
    endfunction

    function automatic int cnt_bit(input int pos);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][pos]) n++;
        return n;
    endfunction

    task automatic model_reset();
        fb.delete();
        m_field = 5'd0; m_char = 4'd0; m_data = 8'd0; m_code = 2'd0; m_idle = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic [23:0] e);
        logic st, sb, ok, er;
        logic [1:0] code_n;
        logic [7:0] cs;
        int len, sp, lastc, commas, n;
        bit match;
        st = 1'b0; sb = 1'b0; ok = 1'b0; er = 1'b0; code_n = m_code; m_idle = 0;
        len = fb.size(); sp = -1; lastc = 5; commas = 0;
        foreach (fb[i]) begin
            if (fb[i] == 8'h2A) sp = i;
            if (fb[i] == 8'h2C) begin lastc = i; commas++; end
        end
        if (b == 8'h24) begin
            fb.delete(); fb.push_back(b);
        end else if (len == 0) begin
            st = 1'b0;
        end else if (sp < 0 && len < 6) begin
            if (len + 1 >= MAX_LEN) begin er = 1'b1; code_n = 2'd2; end
            else begin
                fb.push_back(b);
                if (len + 1 == 6) begin
                    match = 1'b1;
                    for (int i = 0; i < 5; i++) if (fb[i+1] != hdr_str[i]) match = 1'b0;
                    if (match) begin st = 1'b1; m_field = 5'd0; m_char = 4'd0; end
                    else fb.delete();
                end
            end
        end else if (sp < 0) begin
            if (len + 1 >= MAX_LEN) begin er = 1'b1; code_n = 2'd2; end
            else if (b == 8'h2C) begin
                fb.push_back(b); commas++;
                if (commas > 31) m_field = 5'd31; else m_field = commas[4:0];
                m_char = 4'd0;
            end else if (b == 8'h2A) begin
                fb.push_back(b);
            end else begin
                n = len - 1 - lastc;
                if (n > 15) m_char = 4'd15; else m_char = n[3:0];
                m_data = b; sb = 1'b1; fb.push_back(b);
            end
        end else if (len == sp + 1) begin
            if (len + 1 >= MAX_LEN) begin er = 1'b1; code_n = 2'd2; end
            else if (!is_hex(b)) begin er = 1'b1; code_n = 2'd1; end
            else fb.push_back(b);
        end else begin
            if (!is_hex(b)) begin er = 1'b1; code_n = 2'd1; end
            else begin
                cs = 8'd0;
                for (int i = 1; i < sp; i++) cs ^= fb[i];
                if ({hex_val(fb[sp+1]), hex_val(b)} == cs) ok = 1'b1;
                else begin er = 1'b1; code_n = 2'd0; end
                fb.delete();
            end
        end
        if (er) begin m_code = code_n; fb.delete(); end
        e = {(fb.size() != 0), st, sb, ok, er, m_code, m_field, m_char, m_data};
    endtask

    task automatic model_idle(output logic [23:0] e);
        logic er;
        er = 1'b0;
`ifdef NMEA_TIMEOUT_EN
        if (fb.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin er = 1'b1; m_code = 2'd3; fb.delete(); m_idle = 0; end
        end
`endif
        e = {(fb.size() != 0), 1'b0, 1'b0, 1'b0, er, m_code, m_field, m_char, m_data};
    endtask

    task automatic drive_byte(input logic [7:0] b);
        logic [23:0] e;
        po_flag = 1'b1; po_data = b;
        model_byte(b, e);
        @(negedge sys_clk);
        po_flag = 1'b0;
        obs_q.push_back(snap());
        exp_q.push_back(e);
    endtask

    task automatic drive_idle(input int n);
        logic [23:0] e;
        for (int k = 0; k < n; k++) begin
            model_idle(e);
            @(negedge sys_clk);
            obs_q.push_back(snap());
            exp_q.push_back(e);
        end
    endtask

    task automatic send_stim(input int gapmax);
        foreach (stim[i]) begin
            drive_byte(stim[i]);
            if (gapmax > 0) drive_idle($urandom_range(gapmax, 0));
        end
        stim.delete();
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Append '*' and checksum (+delta) of the sentence started by the last '$'.
    task automatic add_checksum(input logic [7:0] delta);
        int d = 0;
        logic [7:0] cs = 8'd0;
        foreach (stim[i]) if (stim[i] == 8'h24) d = i;
        for (int i = d + 1; i < stim.size(); i++) cs ^= stim[i];
        cs = cs + delta;
        stim.push_back(8'h2A);
        stim.push_back(hex_char(cs[7:4]));
        stim.push_back(hex_char(cs[3:0]));
    endtask

    task automatic add_body(input int maxf);
        int nf = $urandom_range(6, 1);
        for (int f = 0; f < nf; f++) begin
            int nc = $urandom_range(maxf, 0);
            stim.push_back(8'h2C);
            for (int c = 0; c < nc; c++) stim.push_back(fchars[$urandom_range(15, 0)]);
        end
    endtask

    task automatic clear_q();
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        model_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (snap() !== 24'd0) begin errors++; $display("FAIL reset_state: got %h expected %h", snap(), 24'd0); end
        sys_rst_n = 1'b1;
        clear_q();
        add_str("$GNRMC,12");
        send_stim(1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (snap() !== 24'd0) begin errors++; $display("FAIL reset_midframe: got %h expected %h", snap(), 24'd0); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_seq step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_valid_sentence();
        int f1 = 0;
        int first_strobe = -1;
        clear_q();
        add_str("$GNRMC,123519.00,A");
        add_checksum(8'd0);
        send_stim(2);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL valid step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][21] && obs_q[i][16:12] == 5'd1) f1++;
            if (obs_q[i][21] && first_strobe < 0) first_strobe = i;
        end
        checks++;
        if (cnt_bit(22) !== 1) begin errors++; $display("FAIL valid_starts: got %0d expected 1", cnt_bit(22)); end
        checks++;
        if (f1 !== 9) begin errors++; $display("FAIL valid_field1_strobes: got %0d expected 9", f1); end
        checks++;
        if (cnt_bit(20) !== 1) begin errors++; $display("FAIL valid_ok: got %0d expected 1", cnt_bit(20)); end
        checks++;
        if (first_strobe < 0 || obs_q[first_strobe][16:0] !== {2'd0, 5'd1, 4'd0, 8'h31}) begin
            errors++; $display("FAIL valid_first_char: got idx %0d expected field 1 char 0 data 31", first_strobe);
        end
    endtask

    task automatic test_bad_checksum();
        clear_q();
        add_str("$GNRMC,123519.00,A");
        add_checksum(8'd1);
        send_stim(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL badcs step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (cnt_bit(19) !== 1 || cnt_bit(20) !== 0 || obs_q[obs_q.size()-1][18:17] !== 2'd0) begin
            errors++; $display("FAIL badcs_result: got err %0d ok %0d code %0d expected 1 0 0", cnt_bit(19), cnt_bit(20), obs_q[obs_q.size()-1][18:17]);
        end
    endtask

    task automatic test_bad_header();
        clear_q();
        add_str("$GNGGA,1*00");
        send_stim(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL badhdr step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[5][23] !== 1'b0) begin errors++; $display("FAIL badhdr_busy: got %b expected 0", obs_q[5][23]); end
        checks++;
        if (cnt_bit(22) + cnt_bit(21) + cnt_bit(20) + cnt_bit(19) !== 0) begin
            errors++; $display("FAIL badhdr_pulses: got %0d expected 0", cnt_bit(22) + cnt_bit(21) + cnt_bit(20) + cnt_bit(19));
        end
    endtask

    task automatic test_restart();
        clear_q();
        add_str("$GNRMC,12$GNRMC,3");
        add_checksum(8'd0);
        send_stim(1);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (cnt_bit(20) !== 1 || cnt_bit(22) !== 2 || cnt_bit(19) !== 0) begin
            errors++; $display("FAIL restart_counts: got ok %0d start %0d err %0d expected 1 2 0", cnt_bit(20), cnt_bit(22), cnt_bit(19));
        end
    endtask

    task automatic test_bad_hex();
        clear_q();
        add_str("$GNRMC,1*4g");
        send_stim(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL badhex step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (cnt_bit(19) !== 1 || obs_q[obs_q.size()-1][18:17] !== 2'd1) begin
            errors++; $display("FAIL badhex_result: got err %0d code %0d expected 1 1", cnt_bit(19), obs_q[obs_q.size()-1][18:17]);
        end
    endtask

    task automatic test_overlength();
        clear_q();
        add_str("$GNRMC");
        for (int i = 0; i < 90; i++) stim.push_back(8'h35);
        send_stim(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL overlen step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[81][19] !== 1'b1 || obs_q[81][18:17] !== 2'd2 || cnt_bit(19) !== 1) begin
            errors++; $display("FAIL overlen_at_82: got err %b code %0d total %0d expected 1 2 1", obs_q[81][19], obs_q[81][18:17], cnt_bit(19));
        end
    endtask

    task automatic test_timeout();
        clear_q();
        add_str("$GNRMC,");
        send_stim(0);
`ifdef NMEA_TIMEOUT_EN
        drive_idle(TO);
        checks++;
        if (obs_q[obs_q.size()-1][23:17] !== {1'b0, 4'b0001, 2'd3}) begin
            errors++; $display("FAIL timeout_err: got %h expected busy 0 err 1 code 3", obs_q[obs_q.size()-1]);
        end
`else
        drive_idle(TO + 50);
        checks++;
        if (obs_q[obs_q.size()-1][23] !== 1'b1 || cnt_bit(19) !== 0) begin
            errors++; $display("FAIL no_timeout: got busy %b err %0d expected 1 0", obs_q[obs_q.size()-1][23], cnt_bit(19));
        end
`endif
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        add_str("$GNRMC");
        add_body(8);
        add_checksum(8'd0);
        add_str("$GNRMC");
        add_body(8);
        add_checksum(8'd0);
        send_stim(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (cnt_bit(20) !== 2 || cnt_bit(22) !== 2) begin
            errors++; $display("FAIL b2b_counts: got ok %0d start %0d expected 2 2", cnt_bit(20), cnt_bit(22));
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(5, 0);
            clear_q();
            if (kind == 4) add_str("x7,*");
            if (kind == 2) begin
                add_str("$GNRM");
                stim.push_back(8'h41 + 8'($urandom_range(25, 0)));
            end else begin
                add_str("$GNRMC");
            end
            add_body((f % 4 == 0) ? 20 : 8);
            if (kind == 5) begin add_str("$GNRMC"); add_body(6); end
            add_checksum((kind == 1) ? 8'($urandom_range(255, 1)) : 8'd0);
            if (kind == 3) stim[stim.size() - 1 - $urandom_range(1, 0)] = 8'h61 + 8'($urandom_range(25, 0));
            send_stim(2);
            foreach (obs_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random frame %0d step %0d: got %h expected %h", f, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_sentence();
        test_bad_checksum();
        test_bad_header();
        test_restart();
        test_bad_hex();
        test_overlength();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
